// File: rtl/dnn_event_pkg.sv
// Shared types and default constants for the DNN classifier event-toggle block.
package dnn_event_pkg;

    localparam int DNN_CNT_WIDTH_DEF   = 16;
    localparam int DNN_SYNC_STAGES_DEF = 2;
    localparam int DNN_MIN_PULSE_DEF   = 2;
    localparam int DNN_RUN_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_HELD
    } dnn_evt_state_t;

endpackage

// File: rtl/dnn_event_chan.sv
// One classifier channel: input synchronizer, pulse-qualification FSM, event toggle
// and saturating event counter. event_pulse strobes during the cycle whose edge issues an event.
module dnn_event_chan
    import dnn_event_pkg::*;
#(
    parameter int CNT_WIDTH   = DNN_CNT_WIDTH_DEF,
    parameter int SYNC_STAGES = DNN_SYNC_STAGES_DEF,
    parameter int MIN_PULSE   = DNN_MIN_PULSE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 clear_cnt,
    input  logic                 din,
    output logic                 event_pulse,
    output logic                 event_toggle,
    output logic [CNT_WIDTH-1:0] event_cnt
);

    localparam logic [DNN_RUN_W-1:0] MIN_P = DNN_RUN_W'(MIN_PULSE);
    localparam logic [DNN_RUN_W-1:0] ONE_P = DNN_RUN_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    dnn_evt_state_t         state_q;
    logic [DNN_RUN_W-1:0]   run_q;
    logic [DNN_RUN_W-1:0]   run_nxt;

    // Synchronizer runs regardless of enable so re-enable sees a settled level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign run_nxt = run_q + ONE_P;

    always_comb begin
        event_pulse = 1'b0;
        if (enable && s) begin
            case (state_q)
                ST_IDLE: event_pulse = (MIN_P == ONE_P);
                ST_ARM:  event_pulse = (run_nxt == MIN_P);
                default: event_pulse = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            run_q   <= '0;
        end else if (!enable) begin
            state_q <= ST_IDLE;
            run_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s) begin
                        state_q <= event_pulse ? ST_HELD : ST_ARM;
                        run_q   <= ONE_P;
                    end
                end
                ST_ARM: begin
                    if (!s) begin
                        state_q <= ST_IDLE;
                        run_q   <= '0;
                    end else if (event_pulse) begin
                        state_q <= ST_HELD;
                    end else begin
                        run_q <= run_nxt;
                    end
                end
                ST_HELD: begin
                    if (!s) begin
                        state_q <= ST_IDLE;
                        run_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    run_q   <= '0;
                end
            endcase
        end
    end

    // Clear beats a same-edge increment, but the toggle still reports the event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_toggle <= 1'b0;
            event_cnt    <= '0;
        end else begin
            event_toggle <= event_toggle ^ event_pulse;
            if (clear_cnt)
                event_cnt <= '0;
            else if (event_pulse && (event_cnt != {CNT_WIDTH{1'b1}}))
                event_cnt <= event_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dnn_event_toggle.sv
// Qualified event toggles from the async DNN classifier pins, plus event/coincidence counters.
// Optional build macro: DNN_EVENT_COINC_EN enables the coincidence counter (else coinc_cnt = 0).
module dnn_event_toggle
    import dnn_event_pkg::*;
#(
    parameter int CNT_WIDTH   = DNN_CNT_WIDTH_DEF,
    parameter int SYNC_STAGES = DNN_SYNC_STAGES_DEF,
    parameter int MIN_PULSE   = DNN_MIN_PULSE_DEF
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    input  logic                 enable,
    input  logic                 clear_cnt,
    input  logic                 dnn_output_0,
    input  logic                 dnn_output_1,
    output logic                 up_event_toggle,
    output logic                 dn_event_toggle,
    output logic [CNT_WIDTH-1:0] up_event_cnt,
    output logic [CNT_WIDTH-1:0] dn_event_cnt,
    output logic [CNT_WIDTH-1:0] coinc_cnt
);

    localparam int NUM_CH = 2;

    logic [NUM_CH-1:0]                din;
    logic [NUM_CH-1:0]                evt;
    logic [NUM_CH-1:0]                tog;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt;

    assign din = {dnn_output_1, dnn_output_0};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dnn_event_chan #(
            .CNT_WIDTH   (CNT_WIDTH),
            .SYNC_STAGES (SYNC_STAGES),
            .MIN_PULSE   (MIN_PULSE)
        ) u_chan (
            .clk          (S_AXI_ACLK),
            .rst_n        (S_AXI_ARESETN),
            .enable       (enable),
            .clear_cnt    (clear_cnt),
            .din          (din[g]),
            .event_pulse  (evt[g]),
            .event_toggle (tog[g]),
            .event_cnt    (cnt[g])
        );
    end

    assign up_event_toggle = tog[0];
    assign dn_event_toggle = tog[1];
    assign up_event_cnt    = cnt[0];
    assign dn_event_cnt    = cnt[1];

`ifdef DNN_EVENT_COINC_EN
    logic [CNT_WIDTH-1:0] coinc_q;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)
            coinc_q <= '0;
        else if (clear_cnt)
            coinc_q <= '0;
        else if ((&evt) && (coinc_q != {CNT_WIDTH{1'b1}}))
            coinc_q <= coinc_q + 1'b1;
    end

    assign coinc_cnt = coinc_q;
`else
    logic unused_evt;
    assign unused_evt = &evt;
    assign coinc_cnt  = '0;
`endif

endmodule

// File: tb/tb_dnn_event_toggle.sv
// Directed bench for dnn_event_toggle (CNT_WIDTH=4, SYNC_STAGES=2, MIN_PULSE=2).
module tb_dnn_event_toggle;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          clear_cnt;
    logic          d0;
    logic          d1;
    logic          up_tog;
    logic          dn_tog;
    logic [CW-1:0] up_cnt;
    logic [CW-1:0] dn_cnt;
    logic [CW-1:0] co_cnt;

    int checks = 0;
    int errors = 0;

`ifdef DNN_EVENT_COINC_EN
    localparam int COINC_EXP = 1;
`else
    localparam int COINC_EXP = 0;
`endif

    always #5 clk = ~clk;

    dnn_event_toggle #(
        .CNT_WIDTH   (CW),
        .SYNC_STAGES (2),
        .MIN_PULSE   (2)
    ) u_dut (
        .S_AXI_ACLK      (clk),
        .S_AXI_ARESETN   (rst_n),
        .enable          (enable),
        .clear_cnt       (clear_cnt),
        .dnn_output_0    (d0),
        .dnn_output_1    (d1),
        .up_event_toggle (up_tog),
        .dn_event_toggle (dn_tog),
        .up_event_cnt    (up_cnt),
        .dn_event_cnt    (dn_cnt),
        .coinc_cnt       (co_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing 1ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse0(input int hi, input int lo);
        d0 = 1'b1;
        step(hi);
        d0 = 1'b0;
        step(lo);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; clear_cnt = 1'b0; d0 = 1'b0; d1 = 1'b0;
        step(2);
        chk("rst_up_tog", up_tog, 0);
        chk("rst_dn_tog", dn_tog, 0);
        chk("rst_up_cnt", up_cnt, 0);
        chk("rst_dn_cnt", dn_cnt, 0);
        chk("rst_coinc",  co_cnt, 0);
        rst_n = 1'b1; enable = 1'b1;
        step(2);

        // Channel 0 high for 10 cycles: one event, exactly 4 edges after the pin rises
        d0 = 1'b1;
        step(3);
        chk("up_lat_before", up_tog, 0);
        step(1);
        chk("up_lat_at", up_tog, 1);
        chk("up_lat_cnt", up_cnt, 1);
        step(6);
        d0 = 1'b0;
        step(4);
        chk("up_long_tog", up_tog, 1);
        chk("up_long_cnt", up_cnt, 1);
        chk("up_long_dn_cnt", dn_cnt, 0);
        chk("up_long_dn_tog", dn_tog, 0);

        // Channel 1 glitch rejected, then a real pulse
        d1 = 1'b1;
        step(1);
        d1 = 1'b0;
        step(5);
        chk("dn_glitch_tog", dn_tog, 0);
        chk("dn_glitch_cnt", dn_cnt, 0);
        d1 = 1'b1;
        step(5);
        d1 = 1'b0;
        step(4);
        chk("dn_evt_tog", dn_tog, 1);
        chk("dn_evt_cnt", dn_cnt, 1);

        // Both rise together: both toggles flip on the same edge
        d0 = 1'b1; d1 = 1'b1;
        step(3);
        chk("coinc_pre_up", up_tog, 1);
        chk("coinc_pre_dn", dn_tog, 1);
        chk("coinc_pre_cnt", co_cnt, 0);
        step(1);
        chk("coinc_up_tog", up_tog, 0);
        chk("coinc_dn_tog", dn_tog, 0);
        chk("coinc_up_cnt", up_cnt, 2);
        chk("coinc_dn_cnt", dn_cnt, 2);
        chk("coinc_cnt", co_cnt, COINC_EXP);
        d0 = 1'b0; d1 = 1'b0;
        step(4);

        // Clear pulse zeroes every counter, toggles hold
        clear_cnt = 1'b1;
        step(1);
        clear_cnt = 1'b0;
        chk("clr_up_cnt", up_cnt, 0);
        chk("clr_dn_cnt", dn_cnt, 0);
        chk("clr_coinc", co_cnt, 0);
        chk("clr_up_tog", up_tog, 0);

        // 20 events on channel 0: counter saturates at 15, toggle flips each time
        for (int i = 0; i < 20; i++) begin
            pulse0(3, 2);
            chk("sat_tog", up_tog, (i + 1) % 2);
            chk("sat_cnt", up_cnt, (i + 1 > 15) ? 15 : i + 1);
        end
        step(3);
        chk("sat_final_tog", up_tog, 0);
        chk("sat_final_cnt", up_cnt, 15);
        chk("sat_dn_cnt", dn_cnt, 0);
        clear_cnt = 1'b1;
        step(1);
        clear_cnt = 1'b0;
        chk("sat_clr_cnt", up_cnt, 0);

        // Clear on the event edge: counter stays 0, toggle still flips
        d0 = 1'b1;
        step(3);
        clear_cnt = 1'b1;
        step(1);
        clear_cnt = 1'b0;
        chk("clr_evt_cnt", up_cnt, 0);
        chk("clr_evt_tog", up_tog, 1);
        d0 = 1'b0;
        step(4);

        // Enable dropped while in ARM: no event; re-enable qualifies after MIN_PULSE
        d0 = 1'b1;
        step(3);
        enable = 1'b0;
        step(1);
        chk("en_abort_tog", up_tog, 1);
        chk("en_abort_cnt", up_cnt, 0);
        step(5);
        chk("en_off_tog", up_tog, 1);
        chk("en_off_cnt", up_cnt, 0);
        enable = 1'b1;
        step(1);
        chk("en_re_before", up_tog, 1);
        step(1);
        chk("en_re_tog", up_tog, 0);
        chk("en_re_cnt", up_cnt, 1);
        d0 = 1'b0;
        step(4);

        // Build up cnt=3/toggle=1, then reset mid-ARM
        clear_cnt = 1'b1;
        step(1);
        clear_cnt = 1'b0;
        repeat (3) pulse0(3, 2);
        step(2);
        chk("pre_rst_cnt", up_cnt, 3);
        chk("pre_rst_tog", up_tog, 1);
        d0 = 1'b1;
        step(3);
        rst_n = 1'b0;
        #1;
        chk("arst_up_tog", up_tog, 0);
        chk("arst_up_cnt", up_cnt, 0);
        chk("arst_dn_cnt", dn_cnt, 0);
        chk("arst_dn_tog", dn_tog, 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("post_rst_before", up_tog, 0);
        step(1);
        chk("post_rst_tog", up_tog, 1);
        chk("post_rst_cnt", up_cnt, 1);
        step(6);
        chk("post_rst_once", up_cnt, 1);
        d0 = 1'b0;
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
